time_set_ctrl: RTL and testbench
================================

Name: time_set_ctrl

Overview:
- User-entry controller that sequences the BCD time/alarm load into the clock datapath.
- Takes level button inputs and snapshots the current time. The user edits hours, minutes and seconds field by field with BCD wrap-around.
- On commit, it drives itime, set and a stretched new pulse into the clock core.
- Sits between the board button/debounce logic and the clock core. The edit value is also exported so the display mux can show it.

Parameters:
- TIMEOUT_CYCLES, 1000000000, idle cycles in an edit state before auto-abort (10 s at 100 MHz); counter width 30 bits.
- NEW_PULSE_CYCLES, 4, cycles new is held high in COMMIT; legal range 1..15.

Ports:
- CLK100MHZ  input  1  system clock
- reset  input  1  synchronous active-high reset
- btn_time  input  1  level, debounced: enter time-set mode
- btn_alarm  input  1  level, debounced: enter alarm-set mode
- btn_next  input  1  level, debounced: advance field / commit
- btn_up  input  1  level, debounced: increment selected field
- btn_down  input  1  level, debounced: decrement selected field
- btn_cancel  input  1  level, debounced: abort edit
- cur_time  input  24  live BCD time {hr,min,sec} from clock core
- itime  output  24  BCD edit value {hr,min,sec}
- set  output  1  1 = commit targets time, 0 = targets alarm
- new  output  1  load strobe, high NEW_PULSE_CYCLES cycles
- editing  output  1  high in any EDIT state
- field  output  2  0 none, 1 hr, 2 min, 3 sec (for display blink)

Behaviour:
- Input edges: each btn_* is registered once. An action fires on the 0->1 edge only, one cycle after the input rises. A held button does not repeat.
- Reset values: itime = 24'h240000, set = 0, new = 0, editing = 0, field = 0, state = IDLE, timeout count = 0, alarm_shadow = 24'h240000.
- Edge registers reset to 1, so a button held through reset does not fire.
- States and transitions:
  - IDLE:
    - btn_time edge: work <= cur_time, set <= 1, go to EDIT_HR.
    - Else btn_alarm edge: work <= alarm_shadow, set <= 0, go to EDIT_HR.
    - btn_time takes priority when both arrive together. All other edges are ignored.
  - EDIT_HR / EDIT_MIN / EDIT_SEC:
    - Priority per cycle is cancel > next > up/down.
    - cancel: go to IDLE, no commit.
    - next: HR->MIN->SEC->COMMIT.
    - up and down together: no change.
  - COMMIT:
    - new = 1 for exactly NEW_PULSE_CYCLES cycles, then IDLE with new = 0.
    - If set = 0, alarm_shadow <= work on COMMIT entry.
    - All button edges are ignored.
- Field arithmetic (pure BCD; result is always valid BCD):
  - Hours range 01..24 (24 = midnight): up 09->10, 19->20, 24->01; down 10->09, 20->19, 01->24.
  - Minutes/seconds range 00..59: up 09->10, 59->00; down 10->09, 00->59.
  - Snapshot values outside the legal range are clamped on entry: hr > 24 or hr = 0 -> 24; min/sec > 59 -> 00.
  - itime is therefore never 0 during COMMIT.
- Outputs:
  - itime = work at all times, registered.
  - set changes only on entry to an EDIT state and is stable throughout COMMIT.
  - editing = 1 in EDIT states only.
  - field = 1/2/3 in EDIT_HR/MIN/SEC, otherwise 0.
- Timeout:
  - The counter clears on state entry and on any accepted edge.
  - When it reaches TIMEOUT_CYCLES-1 in an EDIT state, the block goes to IDLE with no commit; work is retained.
  - The counter is inactive in IDLE and COMMIT.
- cur_time changes during editing are ignored; snapshot only.
- Reset asserted in any state: the next cycle is IDLE with new = 0 and the reset values above. A commit in progress is truncated.
- Latency: the btn_next edge in EDIT_SEC gives new = 1 two cycles after the input rises.

Test Plan (TIMEOUT_CYCLES = 50, NEW_PULSE_CYCLES = 4):
- Time set:
  - Stimulus: cur_time = 24'h113045; btn_time; up x2 (hr 11->13); next; down x1 (min 30->29); next; next.
  - Required: new high exactly 4 cycles, set = 1, itime = 24'h132945 throughout; field sequence 1, 2, 3, 0.
- Hour/minute wrap:
  - Stimulus: snapshot hr = 24; up. Then: hr = 01; down. Then: min = 59; up. Then: sec = 00; down.
  - Required: hr = 01, hr = 24, min = 00, sec = 59 respectively. Every itime nibble stays <= 9 in all intermediate cycles.
- Alarm path:
  - Stimulus: btn_alarm; hr up to 06 from 24 (6 presses); next x3. Then btn_alarm again.
  - Required: commit with set = 0, itime = 24'h060000. Re-entry loads work = 24'h060000 from alarm_shadow.
- Cancel and timeout:
  - Stimulus: cancel in EDIT_MIN. Separately: no input for 50 cycles in EDIT_HR.
  - Required: IDLE in both cases; new never asserts; editing = 0 on the next cycle.
- Simultaneous/held inputs:
  - Stimulus: up and down in the same cycle. btn_up held 20 cycles. next and up together.
  - Required: no change; exactly one increment; field advances with no increment.
- Reset mid-COMMIT:
  - Stimulus: assert reset in the 2nd new cycle.
  - Required: new = 0 the next cycle; itime = 24'h240000; state IDLE; alarm_shadow = 24'h240000.

Source files
------------

// File: rtl/time_set_ctrl.sv
// User-entry controller for the BCD time/alarm load: snapshots the live time,
// lets the user edit hr/min/sec with BCD wrap, then strobes the load into the clock core.
module time_set_ctrl #(
    parameter int TIMEOUT_CYCLES   = 1000000000,
    parameter int NEW_PULSE_CYCLES = 4
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        btn_time,
    input  logic        btn_alarm,
    input  logic        btn_next,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_cancel,
    input  logic [23:0] cur_time,
    output logic [23:0] itime,
    output logic        set,
    output logic        new_pulse,   // load strobe into the clock core
    output logic        editing,
    output logic [1:0]  field
);

    typedef enum logic [2:0] {
        IDLE,
        EDIT_HR,
        EDIT_MIN,
        EDIT_SEC,
        COMMIT
    } state_t;

    localparam logic [29:0] TIMEOUT_LAST = 30'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  PULSE_LAST   = 4'(NEW_PULSE_CYCLES - 1);

    localparam int B_TIME   = 0;
    localparam int B_ALARM  = 1;
    localparam int B_UP     = 2;
    localparam int B_DOWN   = 3;
    localparam int B_NEXT   = 4;
    localparam int B_CANCEL = 5;

    state_t      state;
    logic [5:0]  btn_s;
    logic [5:0]  btn_d;
    logic [5:0]  btn_edge;
    logic [29:0] timer;
    logic [3:0]  pulse_cnt;
    logic [23:0] alarm_shadow;
    logic [23:0] bumped;
    logic [23:0] snapshot;

    // ---------------- BCD field helpers ----------------
    function automatic logic [7:0] clamp_hr(input logic [7:0] h);
        if (h[3:0] > 4'd9 || h[7:4] > 4'd2 || h == 8'h00 || h > 8'h24)
            return 8'h24;
        return h;
    endfunction

    function automatic logic [7:0] clamp_60(input logic [7:0] v);
        if (v[3:0] > 4'd9 || v > 8'h59)
            return 8'h00;
        return v;
    endfunction

    function automatic logic [7:0] inc_hr(input logic [7:0] h);
        if (h == 8'h24)
            return 8'h01;
        if (h[3:0] == 4'd9)
            return {h[7:4] + 4'd1, 4'd0};
        return {h[7:4], h[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] dec_hr(input logic [7:0] h);
        if (h == 8'h01)
            return 8'h24;
        if (h[3:0] == 4'd0)
            return {h[7:4] - 4'd1, 4'd9};
        return {h[7:4], h[3:0] - 4'd1};
    endfunction

    function automatic logic [7:0] inc_60(input logic [7:0] v);
        if (v == 8'h59)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] dec_60(input logic [7:0] v);
        if (v == 8'h00)
            return 8'h59;
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Rising edge of the registered button, so actions land one cycle after the press.
    assign btn_edge = btn_s & ~btn_d;

    assign snapshot = {clamp_hr(cur_time[23:16]), clamp_60(cur_time[15:8]), clamp_60(cur_time[7:0])};

    always_comb begin
        // NOTE: default first so no path leaves bumped unassigned (no latch).
        bumped = itime;
        unique case (state)
            EDIT_HR:  bumped[23:16] = btn_edge[B_UP] ? inc_hr(itime[23:16]) : dec_hr(itime[23:16]);
            EDIT_MIN: bumped[15:8]  = btn_edge[B_UP] ? inc_60(itime[15:8])  : dec_60(itime[15:8]);
            EDIT_SEC: bumped[7:0]   = btn_edge[B_UP] ? inc_60(itime[7:0])   : dec_60(itime[7:0]);
            default:  bumped = itime;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            // Edge registers start high so a button held through reset never fires.
            btn_s        <= '1;
            btn_d        <= '1;
            state        <= IDLE;
            itime        <= 24'h240000;
            alarm_shadow <= 24'h240000;
            set          <= 1'b0;
            new_pulse    <= 1'b0;
            editing      <= 1'b0;
            field        <= 2'd0;
            timer        <= '0;
            pulse_cnt    <= '0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            btn_s <= {btn_cancel, btn_next, btn_down, btn_up, btn_alarm, btn_time};
            btn_d <= btn_s;

            unique case (state)
                IDLE: begin
                    if (btn_edge[B_TIME] || btn_edge[B_ALARM]) begin
                        itime   <= btn_edge[B_TIME] ? snapshot : alarm_shadow;
                        set     <= btn_edge[B_TIME];
                        state   <= EDIT_HR;
                        editing <= 1'b1;
                        field   <= 2'd1;
                        timer   <= '0;
                    end
                end

                EDIT_HR, EDIT_MIN, EDIT_SEC: begin
                    if (btn_edge[B_CANCEL]) begin
                        state   <= IDLE;
                        editing <= 1'b0;
                        field   <= 2'd0;
                    end else if (btn_edge[B_NEXT]) begin
                        timer <= '0;
                        if (state == EDIT_SEC) begin
                            state     <= COMMIT;
                            new_pulse <= 1'b1;
                            pulse_cnt <= '0;
                            editing   <= 1'b0;
                            field     <= 2'd0;
                            if (!set)
                                alarm_shadow <= itime;
                        end else begin
                            state <= (state == EDIT_HR) ? EDIT_MIN : EDIT_SEC;
                            field <= field + 2'd1;
                        end
                    end else if (btn_edge[B_UP] || btn_edge[B_DOWN]) begin
                        timer <= '0;
                        if (btn_edge[B_UP] != btn_edge[B_DOWN])
                            itime <= bumped;
                    end else if (timer == TIMEOUT_LAST) begin
                        state   <= IDLE;
                        editing <= 1'b0;
                        field   <= 2'd0;
                    end else begin
                        timer <= timer + 30'd1;
                    end
                end

                COMMIT: begin
                    if (pulse_cnt == PULSE_LAST) begin
                        state     <= IDLE;
                        new_pulse <= 1'b0;
                    end else begin
                        pulse_cnt <= pulse_cnt + 4'd1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    new_pulse <= 1'b0;
                    editing   <= 1'b0;
                    field     <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomized bench for time_set_ctrl against a field-level model of the edit session
// (decimal hr/min/sec, mode flag, alarm shadow) driven one button press at a time.
module tb_time_set_ctrl;

    localparam int TO    = 50;
    localparam int NPULS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_time, btn_alarm, btn_next, btn_up, btn_down, btn_cancel;
    logic [23:0] cur_time;
    logic [23:0] itime;
    logic        set, new_pulse, editing;
    logic [1:0]  field;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: work value, mode and shadow kept as plain decimal integers.
    int  m_h = 24, m_m = 0, m_s = 0;
    int  a_h = 24, a_m = 0, a_s = 0;
    int  m_fld  = 0;
    bit  m_edit = 0;
    bit  m_set  = 0;

    localparam logic [5:0] K_TIME = 6'b000001, K_ALARM = 6'b000010, K_UP = 6'b000100,
                           K_DOWN = 6'b001000, K_NEXT  = 6'b010000, K_CANCEL = 6'b100000;

    time_set_ctrl #(.TIMEOUT_CYCLES(TO), .NEW_PULSE_CYCLES(NPULS)) dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .btn_time  (btn_time),
        .btn_alarm (btn_alarm),
        .btn_next  (btn_next),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_cancel(btn_cancel),
        .cur_time  (cur_time),
        .itime     (itime),
        .set       (set),
        .new_pulse (new_pulse),
        .editing   (editing),
        .field     (field)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    function automatic logic [23:0] model_time();
        return {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s)};
    endfunction

    // Decode a BCD byte; -1 if it is not valid BCD.
    function automatic int from_bcd(input logic [7:0] b);
        if (b[3:0] > 4'd9 || b[7:4] > 4'd9)
            return -1;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit model_apply(input logic [5:0] k);
        bit commit = 0;
        int v;
        if (!m_edit) begin
            if (k[0]) begin
                v = from_bcd(cur_time[23:16]); m_h = (v < 1 || v > 24) ? 24 : v;
                v = from_bcd(cur_time[15:8]);  m_m = (v < 0 || v > 59) ? 0 : v;
                v = from_bcd(cur_time[7:0]);   m_s = (v < 0 || v > 59) ? 0 : v;
                m_set = 1; m_edit = 1; m_fld = 1;
            end else if (k[1]) begin
                m_h = a_h; m_m = a_m; m_s = a_s;
                m_set = 0; m_edit = 1; m_fld = 1;
            end
        end else if (k[5]) begin
            m_edit = 0; m_fld = 0;
        end else if (k[4]) begin
            if (m_fld == 3) begin
                commit = 1; m_edit = 0; m_fld = 0;
                if (!m_set) begin a_h = m_h; a_m = m_m; a_s = m_s; end
            end else begin
                m_fld++;
            end
        end else if (k[2] != k[3]) begin
            case (m_fld)
                1: m_h = k[2] ? (m_h == 24 ? 1 : m_h + 1) : (m_h == 1 ? 24 : m_h - 1);
                2: m_m = k[2] ? (m_m + 1) % 60 : (m_m + 59) % 60;
                default: m_s = k[2] ? (m_s + 1) % 60 : (m_s + 59) % 60;
            endcase
        end
        return commit;
    endfunction

    task automatic drive(input logic [5:0] k);
        {btn_cancel, btn_next, btn_down, btn_up, btn_alarm, btn_time} = k;
    endtask

    function automatic bit all_bcd(input logic [23:0] v);
        for (int i = 0; i < 6; i++)
            if (v[i*4 +: 4] > 4'd9) return 0;
        return 1;
    endfunction

    // One press: hold the buttons, release, then watch long enough for any commit to finish.
    task automatic press(input logic [5:0] k, input int hold);
        bit          exp_commit;
        int          highs = 0;
        logic [23:0] exp_t;
        exp_commit = model_apply(k);
        exp_t = model_time();
        drive(k);
        for (int i = 0; i < hold + 8; i++) begin
            @(negedge clk);
            check("bcd_valid", 32'(all_bcd(itime)), 32'd1);
            if (new_pulse) begin
                highs++;
                check("commit_itime", 32'(itime), 32'(exp_t));
                check("commit_set", 32'(set), 32'(m_set));
            end
            if (i == hold - 1) drive(6'd0);
        end
        check("new_len", 32'(highs), exp_commit ? 32'(NPULS) : 32'd0);
        check("itime", 32'(itime), 32'(exp_t));
        check("field", 32'(field), 32'(m_fld));
        check("editing", 32'(editing), 32'(m_edit));
        if (m_edit) check("set", 32'(set), 32'(m_set));
    endtask

    task automatic idle_wait(input int n);
        int highs = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (new_pulse) highs++;
        end
        check("no_new", 32'(highs), 32'd0);
    endtask

    initial begin
        logic [5:0] k;
        int         r;
        reset = 1'b1;
        cur_time = 24'h000000;
        drive(6'd0);
        btn_time = 1'b1;              // held through reset: must not fire
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_itime", 32'(itime), 32'h240000);
        check("rst_set", 32'(set), 32'd0);
        check("rst_new", 32'(new_pulse), 32'd0);
        check("rst_editing", 32'(editing), 32'd0);
        check("rst_field", 32'(field), 32'd0);
        repeat (4) @(negedge clk);
        check("held_thru_reset", 32'(editing), 32'd0);
        btn_time = 1'b0;
        repeat (2) @(negedge clk);

        // Time set
        cur_time = 24'h113045;
        press(K_TIME, 1);
        cur_time = 24'h000000;         // live time changes are ignored while editing
        press(K_UP, 2); press(K_UP, 1);
        press(K_NEXT, 1); press(K_DOWN, 1);
        press(K_NEXT, 3); press(K_NEXT, 1);
        check("time_set_result", 32'(itime), 32'h132945);

        // Wraps
        cur_time = 24'h245900;
        press(K_TIME, 1); press(K_UP, 1); press(K_DOWN, 1);
        press(K_NEXT, 1); press(K_UP, 1);
        press(K_NEXT, 1); press(K_DOWN, 1);
        check("wrap_result", 32'(itime), 32'h240059);
        press(K_CANCEL, 1);

        // Clamp on entry
        cur_time = 24'h3A7F99;
        press(K_TIME | K_ALARM, 1);
        check("clamp", 32'(itime), 32'h240000);
        press(K_CANCEL, 1);

        // Alarm path and shadow reload
        press(K_ALARM, 1);
        repeat (6) press(K_UP, 1);
        repeat (3) press(K_NEXT, 1);
        press(K_ALARM, 1);
        check("alarm_reload", 32'(itime), 32'h060000);

        // Simultaneous / held inputs
        press(K_UP | K_DOWN, 1);
        press(K_UP, 20);
        press(K_NEXT | K_UP, 2);
        press(K_CANCEL | K_NEXT, 1);

        // Timeout in EDIT_HR
        press(K_ALARM, 1);
        idle_wait(TO - 8);
        check("pre_timeout", 32'(editing), 32'd1);
        idle_wait(12);
        check("timeout_editing", 32'(editing), 32'd0);
        check("timeout_field", 32'(field), 32'd0);
        check("timeout_keep", 32'(itime), 32'h060000);
        m_edit = 0; m_fld = 0;

        // Randomized sessions
        for (int s = 0; s < 20; s++) begin
            if ($urandom_range(3) == 0)
                cur_time = 24'($urandom);
            else
                cur_time = {to_bcd($urandom_range(24, 1)), to_bcd($urandom_range(59)), to_bcd($urandom_range(59))};
            r = $urandom_range(2);
            press((r == 0) ? K_TIME : (r == 1) ? K_ALARM : (K_TIME | K_ALARM), 1);
            for (int p = 0; p < 8 && m_edit; p++) begin
                r = $urandom_range(15);
                k = (r < 6) ? K_UP : (r < 11) ? K_DOWN : (r < 12) ? (K_UP | K_DOWN) :
                    (r < 15) ? K_NEXT : K_CANCEL;
                press(k, $urandom_range(3, 1));
            end
            for (int p = 0; p < 3 && m_edit; p++)
                press(K_NEXT, 1);
        end

        // Reset truncating an alarm commit; also checks commit latency
        press(K_ALARM, 1);
        press(K_DOWN, 1);
        press(K_NEXT, 1); press(K_NEXT, 1);
        btn_next = 1'b1;
        @(negedge clk);
        check("lat_early", 32'(new_pulse), 32'd0);
        btn_next = 1'b0;
        @(negedge clk);
        check("lat_new", 32'(new_pulse), 32'd1);
        @(negedge clk);
        check("second_new", 32'(new_pulse), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_new", 32'(new_pulse), 32'd0);
        check("rst_mid_itime", 32'(itime), 32'h240000);
        check("rst_mid_editing", 32'(editing), 32'd0);
        check("rst_mid_field", 32'(field), 32'd0);
        m_h = 24; m_m = 0; m_s = 0; a_h = 24; a_m = 0; a_s = 0;
        m_edit = 0; m_fld = 0; m_set = 0;
        idle_wait(3);
        press(K_ALARM, 1);
        check("rst_shadow", 32'(itime), 32'h240000);
        press(K_CANCEL, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
